// File: rtl/clken_pkg.sv
// rtl/clken_pkg.sv - shared types and helpers for the clock-enable generator
package clken_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } state_t;

  // Increment that yields f_out_hz from f_clk_hz, rounded to nearest.
  function automatic logic [31:0] calc_inc(input longint unsigned f_clk_hz,
                                           input longint unsigned f_out_hz,
                                           input int unsigned     acc_w);
    longint unsigned num;
    num = (f_out_hz << acc_w) + (f_clk_hz >> 1);
    return 32'(num / f_clk_hz);
  endfunction

endpackage

// File: rtl/clken_gen_if.sv
// rtl/clken_gen_if.sv - control/status bundle between the core wrapper and clken_gen
interface clken_gen_if #(
  parameter int NUM_CH = 3,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic                      pll_locked;
  logic [NUM_CH*ACC_W-1:0]   inc;
  logic [NUM_CH-1:0]         ch_en;
  logic                      sync;
  logic [NUM_CH-1:0]         clken;
  logic                      reset_out;
  logic                      ready;
  logic [CNT_W-1:0]          lock_loss_cnt;

  modport master (
    output pll_locked, inc, ch_en, sync,
    input  clken, reset_out, ready, lock_loss_cnt
  );

  modport slave (
    input  pll_locked, inc, ch_en, sync,
    output clken, reset_out, ready, lock_loss_cnt
  );
endinterface

// File: rtl/clken_acc.sv
// rtl/clken_acc.sv - one phase-accumulator enable channel
module clken_acc #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [ACC_W-1:0] inc,
  output logic             clken
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // Carry out of the ACC_W-bit add is the enable; the residue stays in acc.
  assign sum = {1'b0, acc} + {1'b0, inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      clken <= 1'b0;
    end else if (clr) begin
      acc   <= '0;
      clken <= 1'b0;
    end else if (en) begin
      acc   <= sum[ACC_W-1:0];
      clken <= sum[ACC_W];
    end else begin
      clken <= 1'b0;
    end
  end

endmodule

// File: rtl/clken_gen.sv
// rtl/clken_gen.sv - lock-supervised multi-channel fractional clock-enable generator
module clken_gen
  import clken_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int ACC_W         = 24,
  parameter int SETTLE_CYCLES = 1024,
  parameter int CNT_W         = 8
) (
  input  logic  clk,
  input  logic  reset,
  clken_gen_if.slave bus
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t             state;
  logic               lk_meta;
  logic               lk;
  logic [SET_W-1:0]   settle_cnt;
  logic               reset_out_q;
  logic               ready_q;
  logic [CNT_W-1:0]   loss_cnt;
  logic               acc_clr;
  logic [NUM_CH-1:0]  clken_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lk_meta <= 1'b0;
      lk      <= 1'b0;
    end else begin
      lk_meta <= bus.pll_locked;
      lk      <= lk_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      settle_cnt  <= '0;
      reset_out_q <= 1'b1;
      ready_q     <= 1'b0;
      loss_cnt    <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          reset_out_q <= 1'b1;
          ready_q     <= 1'b0;
          if (lk) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
          end else if (settle_cnt == SET_LAST) begin
            state       <= RUN;
            reset_out_q <= 1'b0;
            ready_q     <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state       <= WAIT_LOCK;
            reset_out_q <= 1'b1;
            ready_q     <= 1'b0;
            if (loss_cnt != {CNT_W{1'b1}})
              loss_cnt <= loss_cnt + 1'b1;
          end
        end
        default: begin
          state       <= WAIT_LOCK;
          reset_out_q <= 1'b1;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  // Lock loss takes priority over sync; both simply clear the channels.
  assign acc_clr = (state != RUN) | ~lk | bus.sync;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clken_acc #(.ACC_W(ACC_W)) u_acc (
      .clk   (clk),
      .reset (reset),
      .clr   (acc_clr),
      .en    (bus.ch_en[i]),
      .inc   (bus.inc[i*ACC_W +: ACC_W]),
      .clken (clken_v[i])
    );
  end

  assign bus.clken         = clken_v;
  assign bus.reset_out     = reset_out_q;
  assign bus.ready         = ready_q;
  assign bus.lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_clken_gen.sv
// tb/tb_clken_gen.sv - directed self-checking bench for clken_gen
module tb_clken_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  clken_gen_if #(.NUM_CH(3), .ACC_W(24), .CNT_W(8)) bus ();

  clken_gen #(
    .NUM_CH(3), .ACC_W(24), .SETTLE_CYCLES(16), .CNT_W(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int pulses;
    int last;
    int bad_gap;
    logic [24:0] macc;

    bus.pll_locked = 1'b0;
    bus.inc        = {24'h0, 24'h100000, 24'h400000};
    bus.ch_en      = 3'b111;
    bus.sync       = 1'b0;

    // reset state
    #2 reset = 1'b1;
    #1;
    chk("rst_clken", 32'(bus.clken), 32'h0);
    chk("rst_reset_out", 32'(bus.reset_out), 32'h1);
    chk("rst_ready", 32'(bus.ready), 32'h0);
    chk("rst_loss_cnt", 32'(bus.lock_loss_cnt), 32'h0);
    step(2);
    reset = 1'b0;
    step(4);
    chk("wait_lock_hold", 32'(bus.reset_out), 32'h1);

    // lock release: 2 + 1 + 16 edges
    bus.pll_locked = 1'b1;
    step(18);
    chk("rel_ready_early", 32'(bus.ready), 32'h0);
    chk("rel_reset_early", 32'(bus.reset_out), 32'h1);
    step(1);
    chk("rel_ready", 32'(bus.ready), 32'h1);
    chk("rel_reset_out", 32'(bus.reset_out), 32'h0);
    chk("rel_clken0", 32'(bus.clken), 32'h0);

    // exact divisors: ch0 /4, ch1 /16, ch2 never
    for (int c = 1; c <= 48; c++) begin
      step(1);
      chk($sformatf("exact_c%0d", c), 32'(bus.clken),
          32'({1'b0, (c % 16 == 0), (c % 4 == 0)}));
    end

    // fractional rate; acc0 is back at 0 after 48 * 0x400000
    bus.inc[23:0] = 24'h555555;
    pulses  = 0;
    last    = -1;
    bad_gap = 0;
    for (int c = 1; c <= 3000; c++) begin
      step(1);
      if (bus.clken[0]) begin
        if (last >= 0 && !((c - last) == 3 || (c - last) == 4)) bad_gap++;
        pulses++;
        last = c;
      end
    end
    chk("frac_gap", 32'(bad_gap), 32'h0);
    chk("frac_count", 32'(pulses), 32'd999);

    // freeze ch0; residue after 3000 steps is 0xFFFC18
    bus.ch_en[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      chk($sformatf("freeze_c%0d", c), 32'(bus.clken[0]), 32'h0);
    end
    bus.ch_en[0] = 1'b1;
    macc = 25'h0FFFC18;
    for (int c = 0; c < 12; c++) begin
      step(1);
      macc = {1'b0, macc[23:0]} + 25'h0555555;
      chk($sformatf("resume_c%0d", c), 32'(bus.clken[0]), 32'(macc[24]));
    end

    // sync phase-aligns channels
    bus.inc[23:0]  = 24'h400000;
    bus.inc[47:24] = 24'h200000;
    step(7);
    bus.sync = 1'b1;
    step(1);
    chk("sync_edge", 32'(bus.clken), 32'h0);
    bus.sync = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk($sformatf("sync_k%0d", k), 32'(bus.clken),
          32'({1'b0, (k == 8), (k % 4 == 0)}));
    end

    // lock loss in RUN
    bus.pll_locked = 1'b0;
    step(2);
    chk("loss_not_yet", 32'(bus.reset_out), 32'h0);
    step(1);
    chk("loss_reset_out", 32'(bus.reset_out), 32'h1);
    chk("loss_ready", 32'(bus.ready), 32'h0);
    chk("loss_clken", 32'(bus.clken), 32'h0);
    chk("loss_cnt1", 32'(bus.lock_loss_cnt), 32'h1);

    // relock, then glitch during SETTLE
    bus.pll_locked = 1'b1;
    step(5);
    bus.pll_locked = 1'b0;
    step(1);
    bus.pll_locked = 1'b1;
    step(18);
    chk("glitch_restart", 32'(bus.ready), 32'h0);
    step(1);
    chk("glitch_ready", 32'(bus.ready), 32'h1);
    chk("glitch_reset_out", 32'(bus.reset_out), 32'h0);
    chk("glitch_cnt", 32'(bus.lock_loss_cnt), 32'h1);

    // saturate the lock-loss counter
    for (int i = 2; i <= 300; i++) begin
      bus.pll_locked = 1'b0;
      step(3);
      bus.pll_locked = 1'b1;
      step(19);
      if (i == 254 || i == 255 || i == 256 || i == 300) begin
        chk($sformatf("sat_ready_%0d", i), 32'(bus.ready), 32'h1);
        chk($sformatf("sat_cnt_%0d", i), 32'(bus.lock_loss_cnt),
            (i > 255) ? 32'd255 : 32'(i));
      end
    end

    // asynchronous reset between edges
    step(5);
    #2 reset = 1'b1;
    #1;
    chk("areset_reset_out", 32'(bus.reset_out), 32'h1);
    chk("areset_ready", 32'(bus.ready), 32'h0);
    chk("areset_clken", 32'(bus.clken), 32'h0);
    chk("areset_cnt", 32'(bus.lock_loss_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
